branch_pc_unit: RTL and testbench
=================================

// Module: branch_pc_unit
// PURPOSE
//  Program-counter stage for the RV32I core; consumes lt/zero from the comparator.
//  Selects comparator mode per funct3, resolves branch/JAL/JALR, and holds the PC register.
//  Handles fetch handshake/stall and misaligned-target trap; feeds fetch and writeback (link PC).
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded while i_rst is high
//  TRAP_VEC  32'h0000_0100  PC loaded on misaligned-target trap
// PORTS
//  i_clk        in   1   clock; all state updates on rising edge
//  i_rst        in   1   synchronous reset, active-high
//  i_inst_vld   in   1   instruction at o_pc is valid this cycle (imem ack)
//  i_stall      in   1   hold: suppresses commit
//  i_br_en      in   1   current instruction is a conditional branch
//  i_jal        in   1   current instruction is JAL
//  i_jalr       in   1   current instruction is JALR
//  i_funct3     in   3   branch funct3
//  i_lt         in   1   comparator less-than result
//  i_zero       in   1   comparator equality (a-b==0) result
//  i_rs1        in   32  rs1 value (JALR base)
//  i_imm        in   32  sign-extended immediate
//  o_br_mode    out  1   comparator mode: 1 unsigned, 0 signed (= i_funct3[1])
//  o_pc         out  32  current fetch address
//  o_pc_req     out  1   fetch request
//  o_pc_plus4   out  32  o_pc+4 (link value)
//  o_taken      out  1   committed control transfer this cycle (comb.)
//  o_misalign   out  1   one-cycle trap pulse (registered)
//  o_mepc       out  32  PC of faulting instruction
//  o_br_cnt     out  32  committed conditional branches (see CONFIGURATION)
//  o_br_tkn_cnt out  32  committed taken conditional branches
// BEHAVIOUR
//  - Reset (sync): o_pc=RESET_PC, state=BOOT, o_misalign=0, o_mepc=0, counters=0.
//  - States: BOOT (req=0, 1 cycle) -> RUN; RUN: req=1; TRAP (req=0, 1 cycle) -> RUN.
//  - commit = RUN & i_inst_vld & ~i_stall. No commit: PC and state hold.
//  - cond by funct3: 000 zero; 001 ~zero; 100/110 lt; 101/111 ~lt; 010/011 never taken.
//  - take = jalr | jal | (br_en & cond); o_taken = commit & take & ~misalign_hit.
//  - Target priority jalr > jal > branch: jalr: (rs1+imm)&~1; jal/branch: pc+imm.
//  - All adds mod 2^32 (wrap silently); pc+4 at 0xFFFF_FFFC gives 0x0000_0000.
//  - misalign_hit = commit & take & target[1]; not-taken branches never trap.
//  - On misalign_hit: next cycle o_pc=TRAP_VEC, o_mepc=faulting PC, o_misalign=1, state=TRAP.
//  - Else on commit: o_pc <= take ? target : pc+4. Latency 1 cycle, no bubble in RUN.
//  - Priority: i_rst > misalign > taken > sequential. i_stall/i_inst_vld ignored in BOOT/TRAP.
//  - Reset mid-stall or mid-TRAP: restart at BOOT, pending trap discarded.
// CONFIGURATION
//  BRANCH_STATS_EN defined: on commit & i_br_en & ~i_jal & ~i_jalr, o_br_cnt+1;
//   also o_br_tkn_cnt+1 if taken. Saturate at 0xFFFF_FFFF; trapping branches count.
//  Undefined: no counter flops; o_br_cnt and o_br_tkn_cnt tied to 0.
// TESTING
//  1 RESET_PC=0x100, i_rst 2 cycles -> o_pc=0x100, req=0 one cycle, then req=1.
//  2 pc=0x100 BLT f3=100 lt=1 imm=0x20 vld -> br_mode=0, taken=1, next pc=0x120;
//    BGEU f3=111 lt=1 -> br_mode=1, taken=0, next pc=0x124.
//  3 i_stall=1 for 3 cycles in RUN -> o_pc constant, o_taken=0; vld=0 same.
//  4 JALR rs1=0x2001 imm=4 -> pc=0x2004; JALR rs1=0x2002 imm=0 at pc=0x2004 ->
//    o_misalign pulse 1 cycle, o_mepc=0x2004, o_pc=TRAP_VEC, req=0 one cycle.
//  5 pc=0xFFFF_FFFC sequential commit -> o_pc=0x0000_0000, o_pc_plus4 wraps likewise.
//  6 BRANCH_STATS_EN: 3 branches (2 taken) + 1 JAL -> o_br_cnt=3, o_br_tkn_cnt=2;
//    macro undefined -> both read 0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// RV32I program-counter stage: branch/JAL/JALR resolution, fetch handshake and misaligned-target trap.
// Optional branch statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inst_vld,
    input  logic        i_stall,
    input  logic        i_br_en,
    input  logic        i_jal,
    input  logic        i_jalr,
    input  logic [2:0]  i_funct3,
    input  logic        i_lt,
    input  logic        i_zero,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_imm,
    output logic        o_br_mode,
    output logic [31:0] o_pc,
    output logic        o_pc_req,
    output logic [31:0] o_pc_plus4,
    output logic        o_taken,
    output logic        o_misalign,
    output logic [31:0] o_mepc,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_br_tkn_cnt
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] jalr_sum;
    logic [31:0] target;
    logic        commit;
    logic        cond;
    logic        take;
    logic        misalign_hit;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cond = 1'b0;
        case (i_funct3)
            3'b000:         cond = i_zero;
            3'b001:         cond = ~i_zero;
            3'b100, 3'b110: cond = i_lt;
            3'b101, 3'b111: cond = ~i_lt;
            default:        cond = 1'b0;
        endcase
    end

    assign commit       = (state == ST_RUN) & i_inst_vld & ~i_stall;
    assign take         = i_jalr | i_jal | (i_br_en & cond);
    assign jalr_sum     = i_rs1 + i_imm;
    assign target       = i_jalr ? {jalr_sum[31:1], 1'b0} : pc + i_imm;
    assign misalign_hit = commit & take & target[1];

    assign o_br_mode  = i_funct3[1];
    assign o_pc       = pc;
    assign o_pc_req   = (state == ST_RUN);
    assign o_pc_plus4 = pc + 32'd4;
    assign o_taken    = commit & take & ~misalign_hit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc         <= RESET_PC;
            state      <= ST_BOOT;
            o_misalign <= 1'b0;
            o_mepc     <= 32'h0000_0000;
        end else begin
            o_misalign <= misalign_hit;
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_TRAP: state <= ST_RUN;
                ST_RUN: begin
                    if (misalign_hit) begin
                        pc     <= TRAP_VEC;
                        o_mepc <= pc;
                        state  <= ST_TRAP;
                    end else if (commit) begin
                        pc <= take ? target : o_pc_plus4;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic br_commit;
    assign br_commit = commit & i_br_en & ~i_jal & ~i_jalr;

    // Trapping branches still count; both counters saturate instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_br_cnt     <= 32'h0000_0000;
            o_br_tkn_cnt <= 32'h0000_0000;
        end else if (br_commit) begin
            if (o_br_cnt != 32'hFFFF_FFFF)
                o_br_cnt <= o_br_cnt + 32'd1;
            if (cond && (o_br_tkn_cnt != 32'hFFFF_FFFF))
                o_br_tkn_cnt <= o_br_tkn_cnt + 32'd1;
        end
    end
`else
    assign o_br_cnt     = 32'h0000_0000;
    assign o_br_tkn_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed sequences, a branch-condition table
// and a randomized run against a behavioural model.
module tb_branch_pc_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] TRP_VEC = 32'h0000_0240;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_vld, stall, br_en, jal, jalr, lt, zero;
    logic [2:0]  funct3;
    logic [31:0] rs1, imm;
    logic        br_mode, pc_req, taken, misalign;
    logic [31:0] pc, pc_plus4, mepc, br_cnt, br_tkn_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_pc_unit #(.RESET_PC(RST_PC), .TRAP_VEC(TRP_VEC)) dut (
        .i_clk(clk), .i_rst(rst), .i_inst_vld(inst_vld), .i_stall(stall),
        .i_br_en(br_en), .i_jal(jal), .i_jalr(jalr), .i_funct3(funct3),
        .i_lt(lt), .i_zero(zero), .i_rs1(rs1), .i_imm(imm),
        .o_br_mode(br_mode), .o_pc(pc), .o_pc_req(pc_req), .o_pc_plus4(pc_plus4),
        .o_taken(taken), .o_misalign(misalign), .o_mepc(mepc),
        .o_br_cnt(br_cnt), .o_br_tkn_cnt(br_tkn_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        inst_vld = 1'b0; stall = 1'b0; br_en = 1'b0; jal = 1'b0; jalr = 1'b0;
        funct3 = 3'b000; lt = 1'b0; zero = 1'b0; rs1 = '0; imm = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Branch condition straight from the mnemonic semantics.
    function automatic bit branch_cond(input logic [2:0] f3, input logic l, input logic z);
        case (f3)
            3'b000:  return z == 1'b1;   // BEQ
            3'b001:  return z == 1'b0;   // BNE
            3'b100:  return l == 1'b1;   // BLT
            3'b101:  return l == 1'b0;   // BGE
            3'b110:  return l == 1'b1;   // BLTU
            3'b111:  return l == 1'b0;   // BGEU
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [2:0] f3;
        logic       be;
        logic       l;
        logic       z;
        logic       exp_mode;
        logic       exp_taken;
        logic [31:0] exp_step;
    } vec_t;

    vec_t vecs[14];

    logic [31:0] exp_pc;
    logic [31:0] cnt0, tkn0;

    // Behavioural model state for the randomized run.
    logic [31:0] m_pc, m_mepc, m_cnt, m_tkn;
    bit          m_active, m_mis;

    initial begin
        idle_inputs();

        // 1: reset, one idle BOOT cycle, then fetch requests.
        do_reset();
        settle();
        check("reset_pc", pc, RST_PC);
        check("boot_req", {31'b0, pc_req}, 32'd0);
        check("reset_misalign", {31'b0, misalign}, 32'd0);
        check("reset_mepc", mepc, 32'd0);
        check("reset_br_cnt", br_cnt, 32'd0);
        check("reset_tkn_cnt", br_tkn_cnt, 32'd0);
        tick();
        settle();
        check("run_req", {31'b0, pc_req}, 32'd1);
        check("run_pc", pc, RST_PC);

        // 2: BLT taken, then BGEU not taken.
        inst_vld = 1'b1; br_en = 1'b1; funct3 = 3'b100; lt = 1'b1; imm = 32'h20;
        settle();
        check("blt_mode", {31'b0, br_mode}, 32'd0);
        check("blt_taken", {31'b0, taken}, 32'd1);
        tick();
        check("blt_pc", pc, 32'h120);
        funct3 = 3'b111;
        settle();
        check("bgeu_mode", {31'b0, br_mode}, 32'd1);
        check("bgeu_taken", {31'b0, taken}, 32'd0);
        tick();
        check("bgeu_pc", pc, 32'h124);

        // 3: stall, then invalid instruction: PC holds, nothing taken.
        br_en = 1'b0; jal = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_taken", {31'b0, taken}, 32'd0);
            tick();
            check("stall_pc", pc, 32'h124);
        end
        stall = 1'b0; inst_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("novld_taken", {31'b0, taken}, 32'd0);
            tick();
            check("novld_pc", pc, 32'h124);
        end
        jal = 1'b0;

        // Condition table: each row is one committed branch with imm=0x20.
        vecs[0]  = '{3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20};
        vecs[1]  = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4};
        vecs[2]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20};
        vecs[3]  = '{3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4};
        vecs[4]  = '{3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4};
        vecs[5]  = '{3'b110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20};
        vecs[6]  = '{3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4};
        vecs[7]  = '{3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20};
        vecs[8]  = '{3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4};
        vecs[9]  = '{3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20};
        vecs[10] = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4};
        vecs[11] = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4};
        vecs[12] = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4};
        vecs[13] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4};
        exp_pc = 32'h124;
        inst_vld = 1'b1; imm = 32'h20;
        foreach (vecs[i]) begin
            funct3 = vecs[i].f3; br_en = vecs[i].be; lt = vecs[i].l; zero = vecs[i].z;
            settle();
            check($sformatf("vec%0d_mode", i), {31'b0, br_mode}, {31'b0, vecs[i].exp_mode});
            check($sformatf("vec%0d_taken", i), {31'b0, taken}, {31'b0, vecs[i].exp_taken});
            tick();
            exp_pc = exp_pc + vecs[i].exp_step;
            check($sformatf("vec%0d_pc", i), pc, exp_pc);
        end
        idle_inputs();

        // 4: aligned JALR (bit 0 cleared), then a misaligned JALR that traps.
        inst_vld = 1'b1; jalr = 1'b1; rs1 = 32'h2001; imm = 32'h4;
        settle();
        check("jalr_taken", {31'b0, taken}, 32'd1);
        tick();
        check("jalr_pc", pc, 32'h2004);
        rs1 = 32'h2002; imm = 32'h0;
        settle();
        check("trap_taken", {31'b0, taken}, 32'd0);
        tick();
        jalr = 1'b0;
        settle();
        check("trap_pulse", {31'b0, misalign}, 32'd1);
        check("trap_mepc", mepc, 32'h2004);
        check("trap_pc", pc, TRP_VEC);
        check("trap_req", {31'b0, pc_req}, 32'd0);
        tick();
        settle();
        check("trap_pulse_end", {31'b0, misalign}, 32'd0);
        check("trap_req_back", {31'b0, pc_req}, 32'd1);
        check("trap_pc_hold", pc, TRP_VEC);

        // 5: PC wrap at the top of the address space.
        jalr = 1'b1; rs1 = 32'hFFFF_FFFC; imm = 32'h0;
        tick();
        jalr = 1'b0;
        settle();
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_plus4", pc_plus4, 32'h0000_0000);
        tick();
        settle();
        check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_plus4", pc_plus4, 32'h0000_0004);

        // 6: branch statistics: 3 branches (2 taken), a JAL flagged as branch, a stalled branch.
        idle_inputs();
        do_reset();
        tick();
        inst_vld = 1'b1; br_en = 1'b1; imm = 32'h8;
        funct3 = 3'b000; zero = 1'b1; tick();
        funct3 = 3'b001; zero = 1'b1; tick();
        funct3 = 3'b100; lt = 1'b1; tick();
        jal = 1'b1; tick();
        jal = 1'b0; stall = 1'b1; tick();
        idle_inputs();
        settle();
`ifdef BRANCH_STATS_EN
        check("stat_br_cnt", br_cnt, 32'd3);
        check("stat_tkn_cnt", br_tkn_cnt, 32'd2);
`else
        check("stat_br_cnt", br_cnt, 32'd0);
        check("stat_tkn_cnt", br_tkn_cnt, 32'd0);
`endif
        check("stat_pc", pc, RST_PC + 32'd8 + 32'd4 + 32'd8 + 32'd8);

        // Randomized run against the behavioural model, starting from reset.
        do_reset();
        m_pc = RST_PC; m_active = 1'b0; m_mis = 1'b0; m_mepc = '0; m_cnt = '0; m_tkn = '0;
        for (int n = 0; n < 400; n++) begin
            bit          commit, take, hit, c;
            int          kind;
            logic [31:0] tgt, sum;
            rst      = ($urandom_range(0, 39) == 0);
            inst_vld = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            funct3   = 3'($urandom);
            lt       = 1'($urandom);
            zero     = 1'($urandom);
            kind     = $urandom_range(0, 4);
            br_en    = (kind == 1) || (kind >= 2 && $urandom_range(0, 1) == 1);
            jal      = (kind == 2) || (kind == 4);
            jalr     = (kind == 3) || (kind == 4);
            rs1      = $urandom;
            imm      = $urandom;
            if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) rs1[1:0] = 2'b00;

            c      = branch_cond(funct3, lt, zero);
            commit = m_active && inst_vld && !stall;
            take   = jalr || jal || (br_en && c);
            sum    = rs1 + imm;
            tgt    = jalr ? (sum & 32'hFFFF_FFFE) : m_pc + imm;
            hit    = commit && take && tgt[1];

            settle();
            check("rnd_pc", pc, m_pc);
            check("rnd_req", {31'b0, pc_req}, {31'b0, m_active});
            check("rnd_plus4", pc_plus4, m_pc + 32'd4);
            check("rnd_mode", {31'b0, br_mode}, {31'b0, funct3[1]});
            check("rnd_taken", {31'b0, taken}, {31'b0, commit && take && !hit});
            check("rnd_misalign", {31'b0, misalign}, {31'b0, m_mis});
            check("rnd_mepc", mepc, m_mepc);
            check("rnd_br_cnt", br_cnt, m_cnt);
            check("rnd_tkn_cnt", br_tkn_cnt, m_tkn);

            if (rst) begin
                m_pc = RST_PC; m_active = 1'b0; m_mis = 1'b0; m_mepc = '0; m_cnt = '0; m_tkn = '0;
            end else begin
`ifdef BRANCH_STATS_EN
                if (commit && br_en && !jal && !jalr) begin
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                    if (c && m_tkn != 32'hFFFF_FFFF) m_tkn = m_tkn + 1;
                end
`endif
                m_mis = hit;
                if (!m_active) begin
                    m_active = 1'b1;
                end else if (hit) begin
                    m_mepc = m_pc; m_pc = TRP_VEC; m_active = 1'b0;
                end else if (commit) begin
                    m_pc = take ? tgt : m_pc + 32'd4;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
